mips_bus_master: RTL and testbench

Parametrised multi-requester Avalon bus master for the multi-cycle MIPS core. Arbitrates N_CH requesters (channel 0 = data port, channel 1 = instruction fetch by default), drives one Avalon-MM transaction at a time, generates byte enables and lane alignment for byte/half/word accesses, and sign/zero-extends load data. It replaces direct decoder-driven `read`/`write`/`byteenable` in `mips_cpu_bus`, adding sub-word access, alignment checking and round-robin arbitration.

---
 rtl/mips_bus_pkg.sv | 39 +++
 rtl/mips_bus_master_if.sv | 21 ++
 rtl/mips_bus_lane.sv | 49 ++++
 rtl/mips_bus_master.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_bus_master.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS Avalon bus master: access-size codes,
// FSM state encoding and the little-endian byte-enable / alignment helpers.
package mips_bus_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Active byte lanes for an access; size 2'b11 behaves as a word.
   function automatic logic [3:0] calc_byteenable(input logic [1:0] size,
                                                  input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Halves must sit on even addresses, words on multiples of four.
   function automatic logic calc_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         default: bad = (addr_lo != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mips_bus_master_if.sv
// Avalon-MM master-side signal bundle shared between the bus master and
// whatever memory or interconnect sits behind it.
interface mips_bus_master_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_bus_lane.sv
// Combinational lane steering: turns a byte address, access size and
// signedness into byte enables, lane-replicated store data, extended load
// data and an alignment error flag.
module mips_bus_lane
   import mips_bus_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] readdata_i,
   output logic [3:0]  byteenable_o,
   output logic [31:0] writedata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign byteenable_o = calc_byteenable(size_i, addr_lo_i);
   assign misaligned_o = calc_misaligned(size_i, addr_lo_i);

   // Replicate narrow store data so the enabled lanes always carry it.
   always_comb begin
      case (size_i)
         SZ_BYTE: writedata_o = {4{wdata_i[7:0]}};
         SZ_HALF: writedata_o = {2{wdata_i[15:0]}};
         default: writedata_o = wdata_i;
      endcase
   end

   // Pick the addressed lane(s) of the read word and extend to 32 bits.
   always_comb begin
      case (addr_lo_i)
         2'd0:    rd_byte = readdata_i[7:0];
         2'd1:    rd_byte = readdata_i[15:8];
         2'd2:    rd_byte = readdata_i[23:16];
         default: rd_byte = readdata_i[31:24];
      endcase
      rd_half = addr_lo_i[1] ? readdata_i[31:16] : readdata_i[15:0];
      case (size_i)
         SZ_BYTE: rdata_o = {{24{signed_i & rd_byte[7]}}, rd_byte};
         SZ_HALF: rdata_o = {{16{signed_i & rd_half[15]}}, rd_half};
         default: rdata_o = readdata_i;
      endcase
   end

endmodule

// File: rtl/mips_bus_master.sv
// Multi-channel Avalon-MM bus master: arbitrates N_CH requesters, runs one
// bus transaction at a time through IDLE/ACCESS/RESP and returns a one-hot
// completion pulse with extended load data or an alignment error.
module mips_bus_master
   import mips_bus_pkg::*;
#(
   parameter int N_CH = 2,
   parameter int RR   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_CH-1:0]      req,
   input  logic [N_CH-1:0]      req_write,
   input  logic [2*N_CH-1:0]    req_size,
   input  logic [N_CH-1:0]      req_signed,
   input  logic [32*N_CH-1:0]   req_addr,
   input  logic [32*N_CH-1:0]   req_wdata,
   output logic [N_CH-1:0]      done,
   output logic                 err,
   output logic [31:0]          rdata,
   mips_bus_master_if.master    bus
);

   localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic            is_store_q, is_store_d;
   logic [1:0]      size_q, size_d;
   logic            signed_q, signed_d;
   logic [1:0]      addr_lo_q, addr_lo_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic [31:0]     address_q, address_d;
   logic [31:0]     writedata_q, writedata_d;
   logic [3:0]      byteenable_q, byteenable_d;
   logic [N_CH-1:0] done_q, done_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic            gnt_found;
   logic [GW-1:0]   gnt_idx;
   logic [GW-1:0]   cand;

   logic            sel_write;
   logic [1:0]      sel_size;
   logic            sel_signed;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;

   logic [1:0]      lane_addr_lo;
   logic [1:0]      lane_size;
   logic            lane_signed;
   logic [3:0]      lane_byteenable;
   logic [31:0]     lane_writedata;
   logic [31:0]     lane_rdata;
   logic            lane_misaligned;

   // Arbiter: fixed priority scans from channel 0, round-robin scans from
   // the channel after the last one granted.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (RR != 0) cand = GW'((int'(last_grant_q) + 1 + k) % N_CH);
         else         cand = GW'(k);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Route the winning channel's request fields to a common set of wires.
   always_comb begin
      sel_write  = 1'b0;
      sel_size   = SZ_WORD;
      sel_signed = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == GW'(i)) begin
            sel_write  = req_write[i];
            sel_size   = req_size[2*i +: 2];
            sel_signed = req_signed[i];
            sel_addr   = req_addr[32*i +: 32];
            sel_wdata  = req_wdata[32*i +: 32];
         end
      end
   end

   // The lane logic sees the incoming request while idle (to latch enables,
   // store data and the alignment verdict) and the latched request afterwards
   // (to extract load data).
   assign lane_addr_lo = (state_q == ST_IDLE) ? sel_addr[1:0] : addr_lo_q;
   assign lane_size    = (state_q == ST_IDLE) ? sel_size      : size_q;
   assign lane_signed  = (state_q == ST_IDLE) ? sel_signed    : signed_q;

   mips_bus_lane u_lane (
      .addr_lo_i    (lane_addr_lo),
      .size_i       (lane_size),
      .signed_i     (lane_signed),
      .wdata_i      (sel_wdata),
      .readdata_i   (bus.readdata),
      .byteenable_o (lane_byteenable),
      .writedata_o  (lane_writedata),
      .rdata_o      (lane_rdata),
      .misaligned_o (lane_misaligned)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: misaligned requests skip the bus cycle entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (gnt_found) state_d = lane_misaligned ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (!bus.waitrequest) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values; done and err are single-cycle pulses.
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      is_store_d   = is_store_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_lo_d    = addr_lo_q;
      read_d       = read_q;
      write_d      = write_q;
      address_d    = address_q;
      writedata_d  = writedata_q;
      byteenable_d = byteenable_q;
      rdata_d      = rdata_q;
      done_d       = '0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               grant_d      = gnt_idx;
               last_grant_d = gnt_idx;
               is_store_d   = sel_write;
               size_d       = sel_size;
               signed_d     = sel_signed;
               addr_lo_d    = sel_addr[1:0];
               if (lane_misaligned) begin
                  done_d[gnt_idx] = 1'b1;
                  err_d           = 1'b1;
               end else begin
                  read_d       = ~sel_write;
                  write_d      = sel_write;
                  address_d    = {sel_addr[31:2], 2'b00};
                  writedata_d  = lane_writedata;
                  byteenable_d = lane_byteenable;
               end
            end
         end
         ST_ACCESS: begin
            if (!bus.waitrequest) begin
               read_d          = 1'b0;
               write_d         = 1'b0;
               done_d[grant_q] = 1'b1;
               if (!is_store_q) rdata_d = lane_rdata;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and latched request; reset discards any transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q      <= '0;
         last_grant_q <= GW'(N_CH - 1);
         is_store_q   <= 1'b0;
         size_q       <= SZ_WORD;
         signed_q     <= 1'b0;
         addr_lo_q    <= 2'b00;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= '0;
         done_q       <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         is_store_q   <= is_store_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         addr_lo_q    <= addr_lo_d;
         read_q       <= read_d;
         write_q      <= write_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         byteenable_q <= byteenable_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.address    = address_q;
   assign bus.writedata  = writedata_q;
   assign bus.byteenable = byteenable_q;
   assign done           = done_q;
   assign err            = err_q;
   assign rdata          = rdata_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed bench for mips_bus_master: one fixed-priority and one round-robin
// instance share the request fields and the Avalon slave responses.
module tb_mips_bus_master;
   import mips_bus_pkg::*;

   localparam int N_CH = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N_CH-1:0]      req_a, req_b;
   logic [N_CH-1:0]      req_write;
   logic [2*N_CH-1:0]    req_size;
   logic [N_CH-1:0]      req_signed;
   logic [32*N_CH-1:0]   req_addr;
   logic [32*N_CH-1:0]   req_wdata;
   logic [N_CH-1:0]      done_a, done_b;
   logic                 err_a, err_b;
   logic [31:0]          rdata_a, rdata_b;
   logic                 waitrequest;
   logic [31:0]          readdata;

   int n_checks = 0;
   int n_pass   = 0;

   mips_bus_master_if bus_a ();
   mips_bus_master_if bus_b ();

   assign bus_a.waitrequest = waitrequest;
   assign bus_a.readdata    = readdata;
   assign bus_b.waitrequest = waitrequest;
   assign bus_b.readdata    = readdata;

   mips_bus_master #(.N_CH(N_CH), .RR(0)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done_a), .err(err_a), .rdata(rdata_a),
      .bus(bus_a)
   );

   mips_bus_master #(.N_CH(N_CH), .RR(1)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done_b), .err(err_b), .rdata(rdata_b),
      .bus(bus_b)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic set_chan(input int ch, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] wd);
      req_write[ch]          = wr;
      req_size[2*ch +: 2]    = sz;
      req_signed[ch]         = sg;
      req_addr[32*ch +: 32]  = addr;
      req_wdata[32*ch +: 32] = wd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Aligned transfer on dut_a with nwait stall cycles, checked cycle by cycle.
   task automatic xfer(input string tag, input int ch, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int nwait, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_done);
      set_chan(ch, wr, sz, sg, addr, wd);
      readdata    = rd;
      waitrequest = 1'b1;
      req_a       = '0;
      req_a[ch]   = 1'b1;
      req_b       = req_a;
      for (int k = 0; k <= nwait; k++) begin
         @(negedge clk);
         chk_val({tag, "_strobe"}, {31'd0, wr ? bus_a.write : bus_a.read}, 32'd1);
         chk_val({tag, "_other"}, {31'd0, wr ? bus_a.read : bus_a.write}, 32'd0);
         chk_val({tag, "_addr"}, bus_a.address, exp_addr);
         chk_val({tag, "_be"}, {28'd0, bus_a.byteenable}, {28'd0, exp_be});
         if (wr) chk_val({tag, "_wdata"}, bus_a.writedata, exp_wd);
         chk_val({tag, "_done_early"}, {30'd0, done_a}, 32'd0);
         waitrequest = (k < nwait);
      end
      @(negedge clk);
      chk_val({tag, "_done"}, {30'd0, done_a}, {30'd0, exp_done});
      chk_val({tag, "_err"}, {31'd0, err_a}, 32'd0);
      chk_val({tag, "_rdata"}, rdata_a, exp_rd);
      chk_val({tag, "_idle_strobes"}, {30'd0, bus_a.read, bus_a.write}, 32'd0);
      req_a       = '0;
      req_b       = '0;
      waitrequest = 1'b0;
      @(negedge clk);
   endtask

   // Misaligned request: error completion one cycle later, no bus strobe.
   task automatic misalign(input string tag, input int ch, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] exp_rd,
                           input logic [1:0] exp_done);
      set_chan(ch, wr, sz, 1'b0, addr, 32'h5555_5555);
      req_a     = '0;
      req_a[ch] = 1'b1;
      req_b     = req_a;
      @(negedge clk);
      chk_val({tag, "_done"}, {30'd0, done_a}, {30'd0, exp_done});
      chk_val({tag, "_err"}, {31'd0, err_a}, 32'd1);
      chk_val({tag, "_strobes"}, {30'd0, bus_a.read, bus_a.write}, 32'd0);
      chk_val({tag, "_rdata"}, rdata_a, exp_rd);
      req_a = '0;
      req_b = '0;
      @(negedge clk);
      chk_val({tag, "_after"}, {28'd0, bus_a.read, bus_a.write, err_a, |done_a}, 32'd0);
   endtask

   // Both channels hold requests; record which channel each completion names.
   task automatic arb_run(input string tag, input bit use_rr, input logic [1:0] e0,
                          input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3);
      logic [1:0] exp_g [4];
      logic [1:0] d;
      int got;
      exp_g[0] = e0; exp_g[1] = e1; exp_g[2] = e2; exp_g[3] = e3;
      got = 0;
      set_chan(0, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0);
      set_chan(1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0200, 32'h0);
      readdata    = 32'h1111_2222;
      waitrequest = 1'b0;
      if (use_rr) begin req_b = 2'b11; req_a = 2'b00; end
      else        begin req_a = 2'b11; req_b = 2'b00; end
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         d = use_rr ? done_b : done_a;
         if (d != 2'b00) begin
            chk_val($sformatf("%s_grant%0d", tag, got), {30'd0, d}, {30'd0, exp_g[got]});
            got++;
         end
      end
      if (got < 4) chk_val({tag, "_timeout"}, got, 32'd4);
      req_a = '0;
      req_b = '0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      req_a       = '0;
      req_b       = '0;
      req_write   = '0;
      req_size    = '0;
      req_signed  = '0;
      req_addr    = '0;
      req_wdata   = '0;
      waitrequest = 1'b0;
      readdata    = '0;
      @(negedge clk);
      do_reset();

      // Reset state
      chk_val("rst_read", {31'd0, bus_a.read}, 32'd0);
      chk_val("rst_write", {31'd0, bus_a.write}, 32'd0);
      chk_val("rst_done", {30'd0, done_a}, 32'd0);
      chk_val("rst_err", {31'd0, err_a}, 32'd0);
      chk_val("rst_rdata", rdata_a, 32'd0);
      chk_val("rst_address", bus_a.address, 32'd0);
      chk_val("rst_writedata", bus_a.writedata, 32'd0);
      chk_val("rst_be", {28'd0, bus_a.byteenable}, 32'd0);

      // Word load, zero wait
      xfer("wload", 0, 1'b0, SZ_WORD, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0,
           32'h0000_1004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2'b01);
      // Signed and unsigned byte loads from lane 3
      xfer("sbload", 0, 1'b0, SZ_BYTE, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0,
           32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b01);
      xfer("ubload", 0, 1'b0, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0,
           32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 2'b01);
      // Half store with three stall cycles; rdata must not move
      xfer("hstore", 0, 1'b1, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 3,
           32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 2'b01);
      // Byte store on channel 1, lane 1
      xfer("bstore1", 1, 1'b1, SZ_BYTE, 1'b0, 32'h0000_3001, 32'h1234_5678, 32'h0, 0,
           32'h0000_3000, 4'b0010, 32'h7878_7878, 32'h0000_0080, 2'b10);
      // Signed upper-half load on channel 1 with one stall
      xfer("shload1", 1, 1'b0, SZ_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1,
           32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001, 2'b10);
      // Size 2'b11 behaves as a word
      xfer("sz11", 0, 1'b0, 2'b11, 1'b1, 32'h0000_4008, 32'h0, 32'h8765_4321, 0,
           32'h0000_4008, 4'b1111, 32'h0, 32'h8765_4321, 2'b01);

      // Misaligned accesses
      misalign("mis_word", 0, 1'b0, SZ_WORD, 32'h0000_1001, 32'h8765_4321, 2'b01);
      misalign("mis_half", 1, 1'b1, SZ_HALF, 32'h0000_2001, 32'h8765_4321, 2'b10);

      // Reset during a stalled read
      set_chan(0, 1'b0, SZ_WORD, 1'b0, 32'h0000_1008, 32'h0);
      readdata    = 32'h0BAD_F00D;
      waitrequest = 1'b1;
      req_a       = 2'b01;
      req_b       = 2'b01;
      @(negedge clk);
      chk_val("rstmid_read_hi", {31'd0, bus_a.read}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_val("rstmid_read_lo", {31'd0, bus_a.read}, 32'd0);
      chk_val("rstmid_done", {30'd0, done_a}, 32'd0);
      chk_val("rstmid_rdata", rdata_a, 32'd0);
      reset = 1'b0;
      req_a = '0;
      req_b = '0;
      waitrequest = 1'b0;
      @(negedge clk);
      chk_val("rstmid_done_after", {30'd0, done_a}, 32'd0);
      xfer("postrst", 0, 1'b0, SZ_WORD, 1'b0, 32'h0000_1008, 32'h0, 32'h0BAD_F00D, 0,
           32'h0000_1008, 4'b1111, 32'h0, 32'h0BAD_F00D, 2'b01);

      // Arbitration with both channels continuously requesting
      do_reset();
      arb_run("rr", 1'b1, 2'b01, 2'b10, 2'b01, 2'b10);
      arb_run("fp", 1'b0, 2'b01, 2'b01, 2'b01, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
